// File: rtl/ripple_count_monitor_pkg.sv
// -----------------------------------------------------------------------------
// ripple_count_monitor_pkg
//   Shared definitions for the ripple-counter monitor slice: default widths,
//   the tracking FSM encoding and a helper that folds the unused encoding
//   back onto SYNC.
// -----------------------------------------------------------------------------
package ripple_count_monitor_pkg;

   localparam int DEFAULT_WIDTH         = 6;
   localparam int DEFAULT_STABLE_CYCLES = 2;
   localparam int DEFAULT_WRAP_W        = 8;

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } state_e;

   // 2'b11 can never be entered; treat it as SYNC so the FSM recovers
   // by reacquiring the count.
   function automatic state_e decode_state(input logic [1:0] raw);
      state_e st;
      case (raw)
         2'd1:    st = ST_TRACK;
         2'd2:    st = ST_ERROR;
         default: st = ST_SYNC;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/ripple_count_monitor_stable_sampler.sv
// -----------------------------------------------------------------------------
// ripple_count_monitor_stable_sampler
//   Brings the asynchronous ripple-counter output into the clk domain through
//   a 2-flop synchronizer, then only accepts a value once it has sat unchanged
//   in the second stage for STABLE_CYCLES edges. Ripple-settling glitches
//   shorter than that never produce an accept.
//
// Ports
//   clk      in   1      system clock, rising edge
//   reset    in   1      synchronous active-high reset, clears every flop
//   restart  in   1      drop the current stability run so the value that is
//                        present gets accepted again once it re-qualifies
//   q_in     in   WIDTH  raw asynchronous counter value
//   value    out  WIDTH  synchronized value that accompanies accept
//   accept   out  1      one-cycle strobe: value has just qualified as stable
// -----------------------------------------------------------------------------
module ripple_count_monitor_stable_sampler
   import ripple_count_monitor_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] value,
   output logic             accept
);

   localparam int RUN_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(STABLE_CYCLES);
   localparam logic [RUN_W-1:0] RUN_ACCEPT = RUN_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] prev_q;
   // One bit per pipeline stage; prev_q only means something once all three
   // stages have been loaded from q_in after reset.
   logic [2:0]       fill_q;
   logic [RUN_W-1:0] run_q;
   logic             same;

   assign same   = fill_q[2] && (sync2_q == prev_q);
   assign value  = prev_q;
   // The run counter saturates above RUN_ACCEPT, so a held value yields
   // exactly one accept until the next change or restart.
   assign accept = same && (run_q == RUN_ACCEPT);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         fill_q  <= '0;
         run_q   <= '0;
      end else begin
         sync1_q <= q_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         fill_q  <= {fill_q[1:0], 1'b1};
         if (restart || !same) begin
            run_q <= '0;
         end else if (run_q != RUN_MAX) begin
            run_q <= run_q + RUN_W'(1);
         end
      end
   end

endmodule

// File: rtl/ripple_count_monitor.sv
// -----------------------------------------------------------------------------
// ripple_count_monitor
//   Synchronous consumer of a 6-bit JK ripple up-counter. Filters the raw
//   count into accepted values and checks that the count only ever advances
//   by +1, flagging wraps, target matches and sequence errors.
//
// Ports
//   clk          in   1       system clock, rising edge
//   reset        in   1       synchronous active-high reset
//   q_in         in   WIDTH   raw ripple-counter output (asynchronous)
//   target       in   WIDTH   compare value for match_pulse
//   clear_err    in   1       leave ERROR and resynchronize (ignored elsewhere)
//   q_stable     out  WIDTH   last accepted count value
//   q_valid      out  1       q_stable was accepted since reset / clear
//   step_pulse   out  1       one cycle: accepted value was previous + 1
//   wrap_pulse   out  1       one cycle: accepted transition max -> 0
//   match_pulse  out  1       one cycle: newly accepted value equals target
//   wrap_count   out  WRAP_W  saturating count of wraps
//   err          out  1       sticky sequence-error flag
//   state        out  2       FSM state (SYNC=0, TRACK=1, ERROR=2)
// -----------------------------------------------------------------------------
module ripple_count_monitor
   import ripple_count_monitor_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
   parameter int WRAP_W        = DEFAULT_WRAP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  q_in,
   input  logic [WIDTH-1:0]  target,
   input  logic              clear_err,
   output logic [WIDTH-1:0]  q_stable,
   output logic              q_valid,
   output logic              step_pulse,
   output logic              wrap_pulse,
   output logic              match_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              err,
   output logic [1:0]        state
);

   logic [WIDTH-1:0] sample_value;
   logic             sample_accept;
   logic             restart;

   ripple_count_monitor_stable_sampler #(
      .WIDTH         (WIDTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_sampler (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .q_in    (q_in),
      .value   (sample_value),
      .accept  (sample_accept)
   );

   // Registered state and outputs
   state_e            state_q;
   logic [WIDTH-1:0]  q_stable_q;
   logic              q_valid_q;
   logic              step_q;
   logic              wrap_q;
   logic              match_q;
   logic [WRAP_W-1:0] wrap_count_q;
   logic              err_q;

   // Next-state values
   state_e            state_d;
   logic [WIDTH-1:0]  q_stable_d;
   logic              q_valid_d;
   logic              step_d;
   logic              wrap_d;
   logic              match_d;
   logic [WRAP_W-1:0] wrap_count_d;
   logic              err_d;

   state_e            state_cur;
   logic [WIDTH-1:0]  q_inc;
   logic              is_new;
   logic              is_step;
   logic              at_max;

   assign q_inc   = q_stable_q + WIDTH'(1);
   assign is_new  = (sample_value != q_stable_q);
   assign is_step = (sample_value == q_inc);
   assign at_max  = &q_stable_q;

   always_comb begin
      state_cur    = decode_state(state_q);
      state_d      = state_cur;
      q_stable_d   = q_stable_q;
      q_valid_d    = q_valid_q;
      step_d       = 1'b0;
      wrap_d       = 1'b0;
      match_d      = 1'b0;
      wrap_count_d = wrap_count_q;
      err_d        = err_q;
      restart      = 1'b0;

      case (state_cur)
         ST_SYNC: begin
            // First accepted value just seeds the tracker; there is no
            // previous value to compare against, so no pulses.
            if (sample_accept) begin
               q_stable_d = sample_value;
               q_valid_d  = 1'b1;
               state_d    = ST_TRACK;
            end
         end

         ST_TRACK: begin
            if (sample_accept && is_new) begin
               q_stable_d = sample_value;
               match_d    = (sample_value == target);
               if (is_step) begin
                  step_d = 1'b1;
                  if (at_max) begin
                     wrap_d = 1'b1;
                     if (!(&wrap_count_q)) begin
                        wrap_count_d = wrap_count_q + WRAP_W'(1);
                     end
                  end
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERROR;
               end
            end
         end

         ST_ERROR: begin
            // clear_err beats a same-edge acceptance: that value is dropped
            // and the sampler re-qualifies whatever is present from scratch.
            if (clear_err) begin
               err_d     = 1'b0;
               q_valid_d = 1'b0;
               state_d   = ST_SYNC;
               restart   = 1'b1;
            end else if (sample_accept) begin
               q_stable_d = sample_value;
            end
         end

         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_SYNC;
         q_stable_q   <= '0;
         q_valid_q    <= 1'b0;
         step_q       <= 1'b0;
         wrap_q       <= 1'b0;
         match_q      <= 1'b0;
         wrap_count_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         q_stable_q   <= q_stable_d;
         q_valid_q    <= q_valid_d;
         step_q       <= step_d;
         wrap_q       <= wrap_d;
         match_q      <= match_d;
         wrap_count_q <= wrap_count_d;
         err_q        <= err_d;
      end
   end

   assign q_stable    = q_stable_q;
   assign q_valid     = q_valid_q;
   assign step_pulse  = step_q;
   assign wrap_pulse  = wrap_q;
   assign match_pulse = match_q;
   assign wrap_count  = wrap_count_q;
   assign err         = err_q;
   assign state       = state_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_ripple_count_monitor
//   Directed bench for ripple_count_monitor with default parameters
//   (WIDTH=6, STABLE_CYCLES=2, WRAP_W=8). A value driven just after a falling
//   edge is settled before the next rising edge (edge 0) and lands in
//   q_stable on edge 4, i.e. the fifth rising edge after it is driven.
// -----------------------------------------------------------------------------
module tb_ripple_count_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] q_in;
   logic [5:0] target;
   logic       clear_err;
   logic [5:0] q_stable;
   logic       q_valid;
   logic       step_pulse;
   logic       wrap_pulse;
   logic       match_pulse;
   logic [7:0] wrap_count;
   logic       err;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ripple_count_monitor dut (
      .clk         (clk),
      .reset       (reset),
      .q_in        (q_in),
      .target      (target),
      .clear_err   (clear_err),
      .q_stable    (q_stable),
      .q_valid     (q_valid),
      .step_pulse  (step_pulse),
      .wrap_pulse  (wrap_pulse),
      .match_pulse (match_pulse),
      .wrap_count  (wrap_count),
      .err         (err),
      .state       (state)
   );

   // Drive a new settled count and stop 1 time unit after its acceptance edge.
   task automatic drive_q(input logic [5:0] v);
      @(negedge clk);
      q_in = v;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; q_in = 6'd0; target = 6'd0; clear_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({q_stable, q_valid, step_pulse, wrap_pulse, match_pulse, wrap_count, err, state} !== 21'd0) begin
         errors++;
         $display("FAIL reset_values q_stable=%0d q_valid=%0b wrap_count=%0d err=%0b state=%0d expected all zero",
                  q_stable, q_valid, wrap_count, err, state);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (q_valid !== 1'b0) begin
         errors++; $display("FAIL sync_edge3_valid got %0b expected 0", q_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (q_valid !== 1'b1 || state !== 2'd1 || q_stable !== 6'd0) begin
         errors++;
         $display("FAIL sync_edge4 q_valid=%0b state=%0d q_stable=%0d expected 1/1/0", q_valid, state, q_stable);
      end
      checks++;
      if ({step_pulse, wrap_pulse, match_pulse} !== 3'b000) begin
         errors++;
         $display("FAIL sync_no_pulses got %b expected 000 (target==value in SYNC)", {step_pulse, wrap_pulse, match_pulse});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({step_pulse, wrap_pulse, match_pulse, err} !== 4'b0000 || state !== 2'd1) begin
         errors++;
         $display("FAIL sync_hold pulses/err=%b state=%0d expected 0000/1", {step_pulse, wrap_pulse, match_pulse, err}, state);
      end
   endtask

   task automatic test_step();
      @(negedge clk);
      target = 6'd20;
      drive_q(6'd1);
      checks++;
      if (q_stable !== 6'd1 || step_pulse !== 1'b1 || err !== 1'b0 || wrap_pulse !== 1'b0) begin
         errors++;
         $display("FAIL step_0_1 q_stable=%0d step=%0b err=%0b wrap=%0b expected 1/1/0/0",
                  q_stable, step_pulse, err, wrap_pulse);
      end
      @(posedge clk);
      #1;
      checks++;
      if (step_pulse !== 1'b0) begin
         errors++; $display("FAIL step_one_cycle step=%0b expected 0", step_pulse);
      end
   endtask

   task automatic test_wrap();
      int match_count;
      match_count = 0;
      for (int v = 2; v <= 62; v++) begin
         drive_q(6'(v));
         if (match_pulse === 1'b1) match_count++;
         checks++;
         if (step_pulse !== 1'b1 || match_pulse !== (v == 20) || q_stable !== 6'(v)) begin
            errors++;
            $display("FAIL walk_%0d step=%0b match=%0b q_stable=%0d expected 1/%0b/%0d",
                     v, step_pulse, match_pulse, q_stable, (v == 20), v);
         end
      end
      checks++;
      if (match_count !== 1) begin
         errors++; $display("FAIL match_once count=%0d expected 1", match_count);
      end
      drive_q(6'd63);
      checks++;
      if (step_pulse !== 1'b1 || wrap_pulse !== 1'b0 || wrap_count !== 8'd0) begin
         errors++;
         $display("FAIL step_62_63 step=%0b wrap=%0b wrap_count=%0d expected 1/0/0", step_pulse, wrap_pulse, wrap_count);
      end
      drive_q(6'd0);
      checks++;
      if (step_pulse !== 1'b1 || wrap_pulse !== 1'b1 || wrap_count !== 8'd1 || match_pulse !== 1'b0) begin
         errors++;
         $display("FAIL wrap_63_0 step=%0b wrap=%0b wrap_count=%0d match=%0b expected 1/1/1/0",
                  step_pulse, wrap_pulse, wrap_count, match_pulse);
      end
      @(posedge clk);
      #1;
      checks++;
      if (wrap_pulse !== 1'b0 || step_pulse !== 1'b0 || wrap_count !== 8'd1) begin
         errors++;
         $display("FAIL wrap_one_cycle wrap=%0b step=%0b wrap_count=%0d expected 0/0/1", wrap_pulse, step_pulse, wrap_count);
      end
   endtask

   task automatic test_error();
      @(negedge clk);
      target = 6'd7;
      for (int v = 1; v <= 5; v++) drive_q(6'(v));
      checks++;
      if (q_stable !== 6'd5 || step_pulse !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL reach_5 q_stable=%0d step=%0b err=%0b expected 5/1/0", q_stable, step_pulse, err);
      end
      drive_q(6'd7);
      checks++;
      if (err !== 1'b1 || state !== 2'd2 || step_pulse !== 1'b0 || q_stable !== 6'd7) begin
         errors++;
         $display("FAIL skip_5_7 err=%0b state=%0d step=%0b q_stable=%0d expected 1/2/0/7", err, state, step_pulse, q_stable);
      end
      checks++;
      if (match_pulse !== 1'b1) begin
         errors++; $display("FAIL match_on_error match=%0b expected 1", match_pulse);
      end
      @(negedge clk);
      target = 6'd3;
      drive_q(6'd3);
      checks++;
      if (q_stable !== 6'd3 || {step_pulse, wrap_pulse, match_pulse} !== 3'b000 || err !== 1'b1 || state !== 2'd2) begin
         errors++;
         $display("FAIL error_follow q_stable=%0d pulses=%b err=%0b state=%0d expected 3/000/1/2",
                  q_stable, {step_pulse, wrap_pulse, match_pulse}, err, state);
      end
      // clear_err on the very edge that would accept 8: the acceptance is dropped.
      @(negedge clk);
      q_in = 6'd8;
      repeat (4) @(posedge clk);
      @(negedge clk);
      clear_err = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (state !== 2'd0 || err !== 1'b0 || q_valid !== 1'b0 || q_stable !== 6'd3) begin
         errors++;
         $display("FAIL clear_wins state=%0d err=%0b q_valid=%0b q_stable=%0d expected 0/0/0/3",
                  state, err, q_valid, q_stable);
      end
      @(negedge clk);
      clear_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (q_stable !== 6'd8 || state !== 2'd1 || q_valid !== 1'b1 || step_pulse !== 1'b0) begin
         errors++;
         $display("FAIL resync q_stable=%0d state=%0d q_valid=%0b step=%0b expected 8/1/1/0",
                  q_stable, state, q_valid, step_pulse);
      end
      @(negedge clk);
      clear_err = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (state !== 2'd1 || err !== 1'b0 || q_valid !== 1'b1) begin
         errors++;
         $display("FAIL clear_in_track state=%0d err=%0b q_valid=%0b expected 1/0/1", state, err, q_valid);
      end
      @(negedge clk);
      clear_err = 1'b0;
   endtask

   task automatic test_glitch();
      int step_count;
      bit saw_15;
      step_count = 0;
      saw_15 = 1'b0;
      @(negedge clk);
      target = 6'd40;
      q_in = 6'd15;
      @(negedge clk);
      q_in = 6'd9;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (q_stable === 6'd15) saw_15 = 1'b1;
         if (step_pulse === 1'b1) step_count++;
      end
      checks++;
      if (saw_15 !== 1'b0) begin
         errors++; $display("FAIL glitch_rejected saw_15=%0b expected 0", saw_15);
      end
      checks++;
      if (q_stable !== 6'd9 || step_count !== 1 || err !== 1'b0) begin
         errors++;
         $display("FAIL glitch_8_9 q_stable=%0d steps=%0d err=%0b expected 9/1/0", q_stable, step_count, err);
      end
   endtask

   task automatic test_wrap_saturate();
      int exp_count;
      for (int i = 0; i < 255; i++) begin
         drive_q(6'd63);
         @(negedge clk);
         clear_err = 1'b1;
         @(negedge clk);
         clear_err = 1'b0;
         repeat (3) @(posedge clk);
         drive_q(6'd0);
         exp_count = (i + 2 > 255) ? 255 : i + 2;
         checks++;
         if (wrap_count !== 8'(exp_count) || wrap_pulse !== 1'b1 || state !== 2'd1) begin
            errors++;
            $display("FAIL wrap_sat_%0d wrap_count=%0d wrap=%0b state=%0d expected %0d/1/1",
                     i, wrap_count, wrap_pulse, state, exp_count);
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (wrap_count !== 8'd0 || state !== 2'd0 || q_valid !== 1'b0 || q_stable !== 6'd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid wrap_count=%0d state=%0d q_valid=%0b q_stable=%0d err=%0b expected all zero",
                  wrap_count, state, q_valid, q_stable, err);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_step();
      test_wrap();
      test_error();
      test_glitch();
      test_wrap_saturate();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
